// File: rtl/axi_sram_responder.sv
// AXI-lite data-memory responder: one outstanding read or write served from a word SRAM.
// Optional build macro AXI_SRAM_RAND_LAT_EN draws each response latency from a 4-bit LFSR.
module axi_sram_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int unsigned DEPTH_LOG2   = 12,
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [2:0]  arsize,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRdLat,
        StRdResp,
        StWrData,
        StWrLat,
        StWrResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        prio_q, prio_d;      // 0: read wins a tie, 1: write wins
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [1:0]  bresp_q, bresp_d;

    logic [31:0] mem [Depth];

    logic [3:0]            lat_val;
    logic                  rd_grant, wr_grant;
    logic                  rd_load, wr_commit, mem_we;
    logic [31:0]           offset;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;

`ifdef AXI_SRAM_RAND_LAT_EN
    logic [3:0] lfsr_q;

    assign lat_val = lfsr_q;

    // x^4 + x^3 + 1 never reaches zero, so latencies stay within 1..15
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 4'b1001;
        end else if ((arvalid && arready) || (awvalid && awready)) begin
            lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        end
    end
`else
    localparam logic [3:0] FixedLat = 4'(RESP_LATENCY);

    assign lat_val = FixedLat;
`endif

    // Decode the address about to be held, so a zero-latency response sees this cycle's request
    always_comb begin
        offset   = addr_d - BASE_ADDR;
        in_range = (addr_d >= BASE_ADDR) && ((offset >> (DEPTH_LOG2 + 2)) == 32'd0);
        idx      = offset[DEPTH_LOG2+1:2];
    end

    assign rd_grant = reset && arvalid && (!awvalid || !prio_q);
    assign wr_grant = reset && awvalid && (!arvalid || prio_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prio_d    = prio_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        arready   = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        rvalid    = 1'b0;
        bvalid    = 1'b0;
        rd_load   = 1'b0;
        wr_commit = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rd_grant) begin
                    arready = 1'b1;
                    addr_d  = araddr;
                    size_d  = arsize;
                    cnt_d   = lat_val;
                    prio_d  = 1'b1;
                    if (lat_val == 4'd0) begin
                        state_d = StRdResp;
                        rd_load = 1'b1;
                    end else begin
                        state_d = StRdLat;
                    end
                end else if (wr_grant) begin
                    awready = 1'b1;
                    wready  = 1'b1;
                    addr_d  = awaddr;
                    cnt_d   = lat_val;
                    prio_d  = 1'b0;
                    if (wvalid) begin
                        wdata_d = wdata;
                        wstrb_d = wstrb;
                        if (lat_val == 4'd0) begin
                            state_d   = StWrResp;
                            wr_commit = 1'b1;
                        end else begin
                            state_d = StWrLat;
                        end
                    end else begin
                        state_d = StWrData;
                    end
                end
            end
            StRdLat: begin
                if (cnt_q <= 4'd1) begin
                    state_d = StRdResp;
                    rd_load = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRdResp: begin
                rvalid = 1'b1;
                if (rready) begin
                    state_d = StIdle;
                end
            end
            StWrData: begin
                // Latency runs from the aw acceptance, so keep counting while data is awaited
                wready = 1'b1;
                if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end
                if (wvalid) begin
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                    if (cnt_q == 4'd0) begin
                        state_d   = StWrResp;
                        wr_commit = 1'b1;
                    end else begin
                        state_d = StWrLat;
                    end
                end
            end
            StWrLat: begin
                if (cnt_q <= 4'd1) begin
                    state_d   = StWrResp;
                    wr_commit = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWrResp: begin
                bvalid = 1'b1;
                if (bready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        bresp_d = bresp_q;
        mem_we  = 1'b0;
        if (rd_load) begin
            if (!in_range) begin
                rdata_d = 32'd0;
                rresp_d = RespDecErr;
            end else if (size_d > 3'd2) begin
                rdata_d = 32'd0;
                rresp_d = RespSlvErr;
            end else begin
                rdata_d = mem[idx];
                rresp_d = RespOkay;
            end
        end
        if (wr_commit) begin
            bresp_d = in_range ? RespOkay : RespDecErr;
            mem_we  = in_range;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            prio_q  <= 1'b0;
            addr_q  <= 32'd0;
            size_q  <= 3'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            rdata_q <= 32'd0;
            rresp_q <= RespOkay;
            bresp_q <= RespOkay;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            bresp_q <= bresp_d;
        end
    end

    // Array contents survive reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_d[b]) begin
                    mem[idx][8*b +: 8] <= wdata_d[8*b +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;
    assign rresp = rresp_q;
    assign bresp = bresp_q;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder built with RESP_LATENCY=2.
module tb_axi_sram_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] d;
    logic [1:0]  r;

    axi_sram_responder #(
        .BASE_ADDR   (32'h8000_0000),
        .DEPTH_LOG2  (12),
        .RESP_LATENCY(2)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .arvalid(arvalid),
        .arready(arready),
        .araddr (araddr),
        .arsize (arsize),
        .rvalid (rvalid),
        .rready (rready),
        .rdata  (rdata),
        .rresp  (rresp),
        .awvalid(awvalid),
        .awready(awready),
        .awaddr (awaddr),
        .wvalid (wvalid),
        .wready (wready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .bvalid (bvalid),
        .bready (bready),
        .bresp  (bresp)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_rvalid();
        int n = 0;
        @(negedge clock);
        while (rvalid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("wait_rvalid", {31'd0, rvalid}, 32'd1);
    endtask

    task automatic wait_bvalid();
        int n = 0;
        @(negedge clock);
        while (bvalid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("wait_bvalid", {31'd0, bvalid}, 32'd1);
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] sz,
                      output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        araddr  = a;
        arsize  = sz;
        arvalid = 1'b1;
        rready  = 1'b1;
        @(negedge clock);
        while (arready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("ar_accept", {31'd0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        wait_rvalid();
        data = rdata;
        resp = rresp;
        tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] st,
                      output logic [1:0] resp);
        int n = 0;
        awaddr  = a;
        wdata   = dat;
        wstrb   = st;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = 1'b1;
        @(negedge clock);
        while (awready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("aw_accept", {31'd0, awready}, 32'd1);
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wait_bvalid();
        resp = bresp;
        tick();
    endtask

    initial begin
        reset   = 1'b0;
        arvalid = 1'b0; araddr = 32'd0; arsize = 3'd2; rready = 1'b0;
        awvalid = 1'b0; awaddr = 32'd0; wvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0;
        bready  = 1'b0;

        // Reset state, with requests pending so gated readies are visible
        repeat (3) tick();
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clock);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rresp", {30'd0, rresp}, 32'd0);
        check("rst_bresp", {30'd0, bresp}, 32'd0);
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        reset = 1'b1;
        tick();

        // Simultaneous ar/aw twice: read first, then write; also read turnaround of L+2
        araddr = 32'h8000_0010; arsize = 3'd2; arvalid = 1'b1; rready = 1'b1;
        awaddr = 32'h8000_0010; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clock);
        check("rr1_arready", {31'd0, arready}, 32'd1);
        check("rr1_awready", {31'd0, awready}, 32'd0);
        check("rr1_wready", {31'd0, wready}, 32'd0);
        tick();
        @(negedge clock);
        check("rlat1_rvalid", {31'd0, rvalid}, 32'd0);
        check("rlat1_arready", {31'd0, arready}, 32'd0);
        tick();
        @(negedge clock);
        check("rlat2_rvalid", {31'd0, rvalid}, 32'd0);
        tick();
        @(negedge clock);
        check("rresp_rvalid", {31'd0, rvalid}, 32'd1);
        tick();
        @(negedge clock);
        check("rr2_rvalid", {31'd0, rvalid}, 32'd0);
        check("rr2_arready", {31'd0, arready}, 32'd0);
        check("rr2_awready", {31'd0, awready}, 32'd1);
        check("rr2_wready", {31'd0, wready}, 32'd1);
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clock);
        check("wlat1_bvalid", {31'd0, bvalid}, 32'd0);
        tick();
        @(negedge clock);
        check("wlat2_bvalid", {31'd0, bvalid}, 32'd0);
        tick();
        @(negedge clock);
        check("wresp_bvalid", {31'd0, bvalid}, 32'd1);
        check("wresp_bresp", {30'd0, bresp}, 32'd0);
        repeat (3) tick();
        @(negedge clock);
        check("bhold_bvalid", {31'd0, bvalid}, 32'd1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        @(negedge clock);
        check("bdone_bvalid", {31'd0, bvalid}, 32'd0);
        tick();
        rd(32'h8000_0010, 3'd2, d, r);
        check("rr_readback", d, 32'hCAFE_F00D);
        check("rr_readback_resp", {30'd0, r}, 32'd0);

        // aw at cycle 0, wvalid at cycle 3: bvalid at cycle 5
        awaddr = 32'h8000_0020; wdata = 32'h1234_5678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
        @(negedge clock);
        check("lw_c0_awready", {31'd0, awready}, 32'd1);
        tick();
        awvalid = 1'b0;
        @(negedge clock);
        check("lw_c1_wready", {31'd0, wready}, 32'd1);
        check("lw_c1_bvalid", {31'd0, bvalid}, 32'd0);
        tick();
        tick();
        wvalid = 1'b1;
        @(negedge clock);
        check("lw_c3_wready", {31'd0, wready}, 32'd1);
        tick();
        wvalid = 1'b0;
        @(negedge clock);
        check("lw_c4_bvalid", {31'd0, bvalid}, 32'd0);
        tick();
        @(negedge clock);
        check("lw_c5_bvalid", {31'd0, bvalid}, 32'd1);
        check("lw_c5_bresp", {30'd0, bresp}, 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        rd(32'h8000_0020, 3'd2, d, r);
        check("lw_readback", d, 32'h1234_5678);

        // Byte-masked write over a known word
        wr(32'h8000_0004, 32'h1122_3344, 4'hF, r);
        wr(32'h8000_0004, 32'hDEAD_BEEF, 4'b0101, r);
        check("mask_bresp", {30'd0, r}, 32'd0);
        rd(32'h8000_0004, 3'd2, d, r);
        check("mask_rdata", d, 32'h11AD_33EF);
        check("mask_rresp", {30'd0, r}, 32'd0);
        rd(32'h8000_0006, 3'd1, d, r);
        check("unaligned_rdata", d, 32'h11AD_33EF);

        // Decode and size errors
        wr(32'h8000_0000, 32'h0BAD_F00D, 4'hF, r);
        wr(32'h9000_0000, 32'hFFFF_FFFF, 4'hF, r);
        check("oor_bresp", {30'd0, r}, 32'd3);
        rd(32'h8000_0000, 3'd2, d, r);
        check("oor_no_write", d, 32'h0BAD_F00D);
        rd(32'h0000_0100, 3'd2, d, r);
        check("oor_rresp", {30'd0, r}, 32'd3);
        check("oor_rdata", d, 32'd0);
        rd(32'h8000_0004, 3'd3, d, r);
        check("size_rresp", {30'd0, r}, 32'd2);
        check("size_rdata", d, 32'd0);

        // Range edges
        wr(32'h8000_3FFC, 32'hA5A5_5A5A, 4'hF, r);
        check("top_bresp", {30'd0, r}, 32'd0);
        rd(32'h8000_3FFC, 3'd2, d, r);
        check("top_rdata", d, 32'hA5A5_5A5A);
        rd(32'h8000_4000, 3'd2, d, r);
        check("past_top_rresp", {30'd0, r}, 32'd3);
        rd(32'h7FFF_FFFC, 3'd2, d, r);
        check("below_base_rresp", {30'd0, r}, 32'd3);

        // rready held low for 20 cycles with another ar waiting
        araddr = 32'h8000_0004; arsize = 3'd2; arvalid = 1'b1; rready = 1'b0;
        @(negedge clock);
        check("bp_ar_accept", {31'd0, arready}, 32'd1);
        tick();
        araddr = 32'h8000_0020;
        wait_rvalid();
        tick();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("bp_rvalid", {31'd0, rvalid}, 32'd1);
            check("bp_rdata", rdata, 32'h11AD_33EF);
            check("bp_arready", {31'd0, arready}, 32'd0);
            tick();
        end
        rready = 1'b1;
        @(negedge clock);
        check("bp_hs_arready", {31'd0, arready}, 32'd0);
        tick();
        @(negedge clock);
        check("bp_next_arready", {31'd0, arready}, 32'd1);
        check("bp_next_rvalid", {31'd0, rvalid}, 32'd0);
        tick();
        arvalid = 1'b0;
        wait_rvalid();
        check("bp_second_rdata", rdata, 32'h1234_5678);
        tick();

        // Reset asserted during a pending read response
        araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b0;
        @(negedge clock);
        check("mr_ar_accept", {31'd0, arready}, 32'd1);
        tick();
        wait_rvalid();
        #1;
        reset = 1'b0;
        #1;
        check("mr_rvalid", {31'd0, rvalid}, 32'd0);
        check("mr_arready", {31'd0, arready}, 32'd0);
        tick();
        @(negedge clock);
        check("mr_hold_arready", {31'd0, arready}, 32'd0);
        tick();
        reset = 1'b1;
        @(negedge clock);
        check("mr_idle_arready", {31'd0, arready}, 32'd1);
        check("mr_idle_rvalid", {31'd0, rvalid}, 32'd0);
        tick();
        arvalid = 1'b0;
        rready  = 1'b1;
        wait_rvalid();
        check("mr_kept_rdata", rdata, 32'hCAFE_F00D);
        check("mr_kept_rresp", {30'd0, rresp}, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
